// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;

    localparam int UART_ST_FULL      = 0;
    localparam int UART_ST_EMPTY     = 1;
    localparam int UART_ST_ACTIVE    = 2;
    localparam int UART_ST_OVF       = 3;
    localparam int UART_ST_COUNT_LSB = 8;
    localparam int UART_ST_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rdata_o always presents the oldest
// entry, so a pop consumes it in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and sticky overflow flag.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wr_en,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

    uart_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        data_q;
    logic              tx_q;
    logic              ovf_q;
    logic              ovf_d;

    logic              wr_txdata;
    logic              wr_status;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [FC_W-1:0]   fifo_count;
    logic              baud_last;
    logic [31:0]       status;
    logic              unused_wdata;

    assign wr_txdata    = bus_wr_en && (bus_addr == UART_TXDATA_OFS);
    assign wr_status    = bus_wr_en && (bus_addr == UART_STATUS_OFS);
    assign baud_last    = (cnt_q == CNT_W'(DIV - 1));
    assign unused_wdata = ^bus_wdata[31:8];

    // The FIFO head is consumed either from idle or at the last cycle of a
    // stop bit, which gives back-to-back frames with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == UART_IDLE) || ((state_q == UART_STOP) && baud_last));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_txdata),
        .wdata_i (bus_wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_status && bus_wdata[UART_ST_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    cnt_q <= '0;
                    if (fifo_pop) begin
                        data_q  <= fifo_rdata;
                        state_q <= UART_START;
                        tx_q    <= 1'b0;
                    end
                end
                UART_START: begin
                    if (baud_last) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= UART_DATA;
                        tx_q    <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                UART_DATA: begin
                    if (baud_last) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= UART_PARITY;
                            tx_q    <= ^data_q;
`else
                            state_q <= UART_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= data_q[bit_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                UART_PARITY: begin
                    if (baud_last) begin
                        cnt_q   <= '0;
                        state_q <= UART_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                UART_STOP: begin
                    if (baud_last) begin
                        cnt_q <= '0;
                        if (fifo_pop) begin
                            data_q  <= fifo_rdata;
                            state_q <= UART_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= UART_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= UART_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[UART_ST_FULL]   = fifo_full;
        status[UART_ST_EMPTY]  = fifo_empty;
        status[UART_ST_ACTIVE] = (state_q != UART_IDLE);
        status[UART_ST_OVF]    = ovf_q;
        status[UART_ST_COUNT_LSB +: UART_ST_COUNT_W] = UART_ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        bus_rdata = '0;
        if ((bus_addr == UART_TXDATA_OFS) || (bus_addr == UART_STATUS_OFS)) begin
            bus_rdata = status;
        end
    end

    assign uart_tx = tx_q;
    assign tx_busy = !fifo_empty || (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at DIV=16; a passive line receiver collects
// transmitted bytes while the main sequence checks timing and STATUS.
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wr_en;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    int ferr   = 0;
    logic [7:0] rx_q[$];
    logic       par_q[$];
    int rx_idx = 0;
    int par_idx = 0;
    int ferr_base = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_wr_en (bus_wr_en),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    // Line receiver: first low sample is start tick 1, then samples mid-bit.
    initial begin : monitor
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                b = '0;
                repeat (8) @(negedge clk);
                ok = (uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (16) @(negedge clk);
                par_q.push_back(uart_tx);
`endif
                repeat (16) @(negedge clk);
                ok = ok && (uart_tx === 1'b1);
                rx_q.push_back(b);
                if (!ok) ferr++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_wr_en = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        @(negedge clk);
        bus_wr_en = 1'b0;
        $display("write addr=%h data=%h status=%h busy=%b", a, d, bus_rdata, tx_busy);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tx_busy), 32'd0);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = 'x;
        if (rx_idx < rx_q.size()) got = 32'(rx_q[rx_idx]);
        rx_idx++;
        chk(tag, got, 32'(exp));
    endtask

    task automatic chk_par(input string tag, input logic exp);
        logic [31:0] got;
        got = 'x;
        if (par_idx < par_q.size()) got = 32'(par_q[par_idx]);
        par_idx++;
        chk(tag, got, 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        bus_wr_en = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = '0;
        tick(3);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_status", bus_rdata, 32'h2);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle_tx", 32'(uart_tx), 32'd1);
            chk("idle_busy", 32'(tx_busy), 32'd0);
            chk("idle_status", bus_rdata, 32'h2);
        end
        bus_addr = 4'h4;
        #1 chk("idle_status_ofs4", bus_rdata, 32'h2);
        bus_addr = 4'h0;

        // Single byte 0x55: exact edges and busy fall at write edge + FRAME + 1.
        wr(4'h0, 32'hFFFF_FF55);
        chk("b55_tx_t0", 32'(uart_tx), 32'd1);
        chk("b55_busy_t0", 32'(tx_busy), 32'd1);
        chk("b55_status_t0", bus_rdata, 32'h0000_0100);
        tick(1);
        chk("b55_start_edge", 32'(uart_tx), 32'd0);
        chk("b55_status_t1", bus_rdata, 32'h0000_0006);
        tick(15);
        chk("b55_start_end", 32'(uart_tx), 32'd0);
        tick(1);
        chk("b55_bit0", 32'(uart_tx), 32'd1);
        tick(16);
        chk("b55_bit1", 32'(uart_tx), 32'd0);
        tick(FRAME - 33);
        chk("b55_busy_last", 32'(tx_busy), 32'd1);
        chk("b55_stop_last", 32'(uart_tx), 32'd1);
        tick(1);
        chk("b55_busy_drop", 32'(tx_busy), 32'd0);
        chk("b55_status_end", bus_rdata, 32'h2);
        chk_rx("b55_rx", 8'h55);

        // Back-to-back: second start bit exactly FRAME cycles after the first.
        wr(4'h0, 32'h41);
        wr(4'h0, 32'h42);
        chk("b2b_start1", 32'(uart_tx), 32'd0);
        chk("b2b_push_pop_status", bus_rdata, 32'h0000_0104);
        tick(FRAME - 1);
        chk("b2b_stop_last", 32'(uart_tx), 32'd1);
        tick(1);
        chk("b2b_start2", 32'(uart_tx), 32'd0);
        wait_idle("b2b_drain", FRAME + 50);
        chk_rx("b2b_rx0", 8'h41);
        chk_rx("b2b_rx1", 8'h42);

        // Nine consecutive writes fit because the first byte pops at cycle 1.
        for (int i = 0; i < 9; i++) wr(4'h0, 32'(i));
        chk("w9_status_peak", bus_rdata, 32'h0000_0805);
        wait_idle("w9_drain", 9 * FRAME + 100);
        chk("w9_status_end", bus_rdata, 32'h2);
        for (int i = 0; i < 9; i++) chk_rx("w9_rx", 8'(i));

        // Ten writes: tenth dropped, overflow sticky until cleared.
        for (int i = 0; i < 10; i++) wr(4'h0, 32'(i));
        chk("w10_status_peak", bus_rdata, 32'h0000_080D);
        wait_idle("w10_drain", 9 * FRAME + 100);
        chk("w10_status_end", bus_rdata, 32'h0000_000A);
        for (int i = 0; i < 9; i++) chk_rx("w10_rx", 8'(i));
        tick(20);
        chk("w10_no_tenth", 32'(rx_q.size()), 32'(rx_idx));
        wr(4'h4, 32'h0000_0007);
        chk("ovf_keep", bus_rdata, 32'h0000_000A);
        wr(4'h4, 32'h0000_0008);
        chk("ovf_clear", bus_rdata, 32'h2);
        wr(4'h8, 32'h77);
        chk("ofs8_read", bus_rdata, 32'h0);
        chk("ofs8_ignored_busy", 32'(tx_busy), 32'd0);
        bus_addr = 4'h0;
        #1 chk("ofs8_ignored_status", bus_rdata, 32'h2);

        // Parity bytes and frame length.
        wr(4'h0, 32'h07);
        tick(FRAME);
        chk("p07_busy_last", 32'(tx_busy), 32'd1);
        tick(1);
        chk("p07_busy_drop", 32'(tx_busy), 32'd0);
        chk_rx("p07_rx", 8'h07);
`ifdef UART_TX_PARITY_EN
        chk_par("p07_parity", 1'b1);
`endif
        wr(4'h0, 32'h03);
        wait_idle("p03_drain", FRAME + 50);
        chk_rx("p03_rx", 8'h03);
`ifdef UART_TX_PARITY_EN
        chk_par("p03_parity", 1'b0);
`endif
        chk("frame_errors", 32'(ferr), 32'd0);

        // Reset during DATA bit1 of 0xA5 forces the line high at once.
        wr(4'h0, 32'hA5);
        tick(40);
        chk("a5_bit1_low", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("a5_rst_tx", 32'(uart_tx), 32'd1);
        chk("a5_rst_busy", 32'(tx_busy), 32'd0);
        chk("a5_rst_status", bus_rdata, 32'h2);
        @(negedge clk);
        rst = 1'b0;
        tick(200);
        rx_idx    = rx_q.size();
        par_idx   = par_q.size();
        ferr_base = ferr;
        wr(4'h0, 32'h3C);
        wait_idle("c3_drain", FRAME + 50);
        chk_rx("c3_rx", 8'h3C);
        chk("c3_frame_ok", 32'(ferr), 32'(ferr_base));
        chk("c3_count", 32'(rx_q.size()), 32'(rx_idx));
`ifdef UART_TX_PARITY_EN
        chk_par("c3_parity", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter sitting directly downstream of the core's data-memory store path. The core's load/store unit decodes the peripheral window and forwards word stores and status reads here. The block buffers bytes in a small FIFO and serialises them 8N1 on `uart_tx`. The instruction-level bench observes the same line to check console output from test programs.

## Interface
Parameters:
- `CLK_FREQ`, default 27_000_000, core clock in Hz.
- `BAUD`, default 115_200, line rate; `DIV = CLK_FREQ / BAUD` (integer, truncated), must be ≥ 2.
- `FIFO_DEPTH`, default 8, power of two, 2–64.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `bus_wr_en`, in, 1: store strobe, one cycle per write.
- `bus_addr`, in, 4: byte offset in window (0x0 TXDATA, 0x4 STATUS, others ignored).
- `bus_wdata`, in, 32: store data.
- `bus_rdata`, out, 32: combinational read of register at `bus_addr`.
- `uart_tx`, out, 1: serial line, idle high.
- `tx_busy`, out, 1: high when FIFO non-empty or a frame is in flight.

## Operation
- TXDATA write: push `bus_wdata[7:0]`; upper bits ignored. TXDATA read returns STATUS.
- STATUS read layout:
  - bit0 full; bit1 empty; bit2 frame active; bit3 sticky overflow.
  - bits[15:8] FIFO count; others 0.
- Write to STATUS with bit3=1 clears overflow; other bits are read-only.
- Push while full: byte dropped, overflow set. Full is evaluated before any same-cycle pop, so the push is dropped even if a pop occurs that cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop into shift register and go to START.
  - START: drive 0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, DIV cycles each, then STOP (PARITY first when enabled).
  - STOP: drive 1 for DIV cycles. If FIFO non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..DIV-1 and is reloaded at every state entry. Bit index is 3 bits and must not wrap past 7.
- Reset values:
  - `uart_tx`=1, `tx_busy`=0, `bus_rdata` reflects empty FIFO (0x0000_0002).
  - FIFO pointers and count 0, overflow 0, FSM IDLE.
  - Reset mid-frame aborts immediately; the line returns high asynchronously.

## Timing
- Write at edge N: count increments at N. Pop and start bit begin at edge N+1, so `uart_tx` falls one cycle after the write edge.
- Frame length is 10·DIV cycles (11·DIV with parity).
- `tx_busy` rises at the edge the first byte is written. It falls at the end of the stop bit of the last byte.
- Simultaneous push and pop with FIFO not full: count unchanged, both take effect.
- `bus_rdata` has zero latency; it reflects state after the most recent edge.

## Configuration
- `UART_TX_PARITY_EN` defined: adds state PARITY between DATA and STOP, driving the even-parity bit (XOR of the 8 data bits) for DIV cycles.
- Undefined: no PARITY state; pure 8N1.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`).
  - Register offsets `UART_TXDATA_OFS`, `UART_STATUS_OFS`.
  - STATUS bit-position constants.
- Sub-module `sync_fifo` (parameterised width/depth; push, pop, full, empty, count). The FSM, baud counter and register decode live in the top module.

## Test plan
Bench uses CLK_FREQ=16, BAUD=1, so DIV=16.
- Reset then idle: `uart_tx`=1, `tx_busy`=0, STATUS read=0x0000_0002 for 100 cycles.
- Write 0x55 to 0x0: line low from cycle +1 for 16 cycles. Then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then stop high. `tx_busy` drops at cycle +161.
- Write 0x41, 0x42 back-to-back: second start bit begins exactly 160 cycles after the first, with no idle gap. Sampled bytes are 0x41, 0x42.
- Nine writes (0x00–0x08) in consecutive cycles with FIFO_DEPTH=8: first byte pops at cycle 1, so the ninth push is accepted and no overflow occurs. Repeat with ten writes: overflow sets, the tenth byte is never transmitted, and count reads 8 at the peak. Writing 0x8 to STATUS clears overflow.
- Assert `rst` mid-DATA of 0xA5: `uart_tx`=1 within the same cycle, STATUS=0x2. A new write of 0x3C transmits cleanly.
- With `UART_TX_PARITY_EN`: 0x07 yields parity bit 1 and 0x03 yields 0. Frame is 176 cycles.
